// File: rtl/emd_pkg.sv
// Shared types and defaults for the EMD sifting path: sample type, direction
// enum and default index/counter widths.
package emd_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int DEF_IDX_W = 12;
    localparam int DEF_CNT_W = 10;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        DIR_IDLE,
        DIR_UP,
        DIR_DOWN
    } dir_t;

    // One bit wider than a sample so the subtraction can never overflow.
    function automatic logic signed [SAMPLE_W:0] wide_diff(input sample_t a, input sample_t b);
        return {a[SAMPLE_W-1], a} - {b[SAMPLE_W-1], b};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/extrema_detect.sv
// Streaming local-extremum detector: strobes value/index of each local max/min
// and counts them per frame. EXTREMA_PLATEAU_EN reports flat runs as one extremum.
module extrema_detect
    import emd_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  sample_t          Xin,
    input  logic             Xin_VALID,
    input  logic             SOF,
    output logic             MAX_VALID,
    output sample_t          MAX_VAL,
    output logic [IDX_W-1:0] MAX_IDX,
    output logic             MIN_VALID,
    output sample_t          MIN_VAL,
    output logic [IDX_W-1:0] MIN_IDX,
    output logic [CNT_W-1:0] N_MAX,
    output logic [CNT_W-1:0] N_MIN,
    output dir_t             DIR_DBG
);

    dir_t             dir_q,       dir_d;
    sample_t          prev_q,      prev_d;
    sample_t          cand_val_q,  cand_val_d;
    logic [IDX_W-1:0] cand_idx_q,  cand_idx_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic             first_q,     first_d;
    logic             max_valid_q, max_valid_d;
    sample_t          max_val_q,   max_val_d;
    logic [IDX_W-1:0] max_idx_q,   max_idx_d;
    logic             min_valid_q, min_valid_d;
    sample_t          min_val_q,   min_val_d;
    logic [IDX_W-1:0] min_idx_q,   min_idx_d;

    logic signed [SAMPLE_W:0] diff;
    logic                     d_zero;
    logic                     d_neg;
    logic                     d_pos;
    logic                     is_first;

    assign diff     = wide_diff(Xin, prev_q);
    assign d_zero   = (diff == '0);
    assign d_neg    = diff[SAMPLE_W];
    assign d_pos    = !d_neg && !d_zero;
    assign is_first = first_q || SOF;

    always_comb begin
        dir_d       = dir_q;
        prev_d      = prev_q;
        cand_val_d  = cand_val_q;
        cand_idx_d  = cand_idx_q;
        idx_d       = idx_q;
        first_d     = first_q;
        max_valid_d = 1'b0;
        max_val_d   = max_val_q;
        max_idx_d   = max_idx_q;
        min_valid_d = 1'b0;
        min_val_d   = min_val_q;
        min_idx_d   = min_idx_q;

        if (Xin_VALID) begin
            prev_d  = Xin;
            first_d = 1'b0;
            if (is_first) begin
                // Any candidate left over from the previous frame is dropped here.
                dir_d      = DIR_IDLE;
                cand_val_d = Xin;
                cand_idx_d = '0;
                idx_d      = IDX_W'(1);
            end else begin
                idx_d = idx_q + IDX_W'(1);
                if (d_pos) begin
                    if (dir_q == DIR_DOWN) begin
                        min_valid_d = 1'b1;
                        min_val_d   = cand_val_q;
                        min_idx_d   = cand_idx_q;
                    end
                    dir_d      = DIR_UP;
                    cand_val_d = Xin;
                    cand_idx_d = idx_q;
                end else if (d_neg) begin
                    if (dir_q == DIR_UP) begin
                        max_valid_d = 1'b1;
                        max_val_d   = cand_val_q;
                        max_idx_d   = cand_idx_q;
                    end
                    dir_d      = DIR_DOWN;
                    cand_val_d = Xin;
                    cand_idx_d = idx_q;
                end else begin
`ifdef EXTREMA_PLATEAU_EN
                    // Hold direction and candidate so the run reports at its first sample.
                    dir_d      = dir_q;
`else
                    dir_d      = DIR_IDLE;
                    cand_val_d = Xin;
                    cand_idx_d = idx_q;
`endif
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dir_q       <= DIR_IDLE;
            prev_q      <= '0;
            cand_val_q  <= '0;
            cand_idx_q  <= '0;
            idx_q       <= '0;
            first_q     <= 1'b1;
            max_valid_q <= 1'b0;
            max_val_q   <= '0;
            max_idx_q   <= '0;
            min_valid_q <= 1'b0;
            min_val_q   <= '0;
            min_idx_q   <= '0;
        end else begin
            dir_q       <= dir_d;
            prev_q      <= prev_d;
            cand_val_q  <= cand_val_d;
            cand_idx_q  <= cand_idx_d;
            idx_q       <= idx_d;
            first_q     <= first_d;
            max_valid_q <= max_valid_d;
            max_val_q   <= max_val_d;
            max_idx_q   <= max_idx_d;
            min_valid_q <= min_valid_d;
            min_val_q   <= min_val_d;
            min_idx_q   <= min_idx_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt_max (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (Xin_VALID && SOF),
        .inc   (max_valid_d),
        .cnt   (N_MAX)
    );

    sat_counter #(.W(CNT_W)) u_cnt_min (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (Xin_VALID && SOF),
        .inc   (min_valid_d),
        .cnt   (N_MIN)
    );

    assign MAX_VALID = max_valid_q;
    assign MAX_VAL   = max_val_q;
    assign MAX_IDX   = max_idx_q;
    assign MIN_VALID = min_valid_q;
    assign MIN_VAL   = min_val_q;
    assign MIN_IDX   = min_idx_q;
    assign DIR_DBG   = dir_q;

endmodule
